qspi_sram_responder: RTL and testbench
======================================

// Module: qspi_sram_responder
// PURPOSE
//   Synthesizable QSPI (SQI-mode) serial-SRAM target. It answers the ram/rom/vram QSPI
//   initiators of hack_soc on cs_n/sck/sio[3:0] and backs them with a byte-wide
//   synchronous memory port. Used in FPGA builds and benches in place of a real 23LC1024.
//   sck is oversampled in the clk domain; no logic is clocked by sck.
// PARAMETERS
//   ADDR_W         17  backing-store address width (bytes); wire address is always 24 bit
//   DUMMY_NIBBLES  2   dummy nibbles between address and read data (one byte)
// PORTS
//   clk        in   1       system clock; must be >= 8x sck frequency
//   reset      in   1       asynchronous, active-high reset
//   cs_n       in   1       chip select from initiator, active low
//   sck        in   1       serial clock, SPI mode 0 (idles low)
//   sio_i      in   4       SIO lines from initiator (sio3..sio0)
//   sio_o      out  4       SIO lines to initiator
//   sio_oe     out  1       1 = responder drives sio_o
//   mem_addr   out  ADDR_W  backing-store byte address
//   mem_re     out  1       read strobe; mem_rdata valid the following clk
//   mem_rdata  in   8       read data
//   mem_we     out  1       write strobe, one clk per byte
//   mem_wdata  out  8       write data
//   busy       out  1       transaction in progress (cs_n synchronized low)
//   cmd_err    out  1       sticky unknown-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset values: sio_o=0, sio_oe=0, mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0,
//     busy=0, cmd_err=0; FSM in IDLE.
//   - cs_n, sck and sio_i pass through 2-flop synchronizers. Rise/fall are detected on the
//     synchronized sck. Inputs are sampled on the detected rise; outputs update on the fall.
//   - One nibble moves per sck rise, most significant nibble first.
//   - FSM:
//     IDLE -> CMD on synchronized cs_n fall.
//     CMD (2 nibbles) -> ADDR. Opcode 0x03 = read, 0x02 = write, otherwise IGNORE.
//     ADDR (6 nibbles). Only the low ADDR_W bits are kept; the upper bits are discarded.
//       Read -> DUMMY; write -> WDATA.
//     DUMMY (DUMMY_NIBBLES nibbles): mem_re pulses once on the clk after the last address
//       nibble. The byte is latched into the shift register. -> RDATA.
//     RDATA: sio_oe=1 from the first sck fall after the last dummy nibble. On each sck fall,
//       sio_o presents the high nibble, then the low nibble. While the high nibble is out,
//       mem_re pulses for addr+1 to prefetch the next byte.
//     WDATA: after each second nibble, mem_wdata = {n0,n1} and mem_we pulses for one clk
//       on the clk after that sck rise; the address then increments.
//     IGNORE: holds until cs_n rises; no memory access.
//   - Addresses increment by 1 per byte and wrap from 2^ADDR_W-1 to 0.
//   - cs_n rising in any state: FSM -> IDLE and sio_oe=0 on the clk it is detected.
//     A partial write byte (odd nibble count) is discarded. In-flight read data is dropped.
//   - Latency: an sck edge at the pin produces its effect within 3 clk (sync + register).
//   - mem_re and mem_we are never high in the same clk.
//   - busy = synchronized ~cs_n.
//   - Reset asserted mid-transaction: immediate return to the reset values. The next
//     transaction needs a fresh cs_n fall.
//   - sck edges while cs_n is high are ignored.
// CONFIGURATION
//   QSPI_RESP_CMD_ERR_EN defined: an unknown opcode sets cmd_err, which holds until reset.
//   Not defined: cmd_err is tied 0. Unknown opcodes still go to IGNORE.
// STRUCTURE
//   Shared package qspi_pkg: opcode constants (QSPI_OP_READ=8'h03, QSPI_OP_WRITE=8'h02),
//   FSM state enum, 24-bit wire-address width constant.
//   Sub-module qspi_edge_sync: 2-flop synchronizers plus sck rise/fall and cs_n fall/rise
//   pulse generation. Reused by any future QSPI target.
// TESTING
//   1. Write 0x02, addr 0x000010, bytes A5 3C -> mem_we twice: (0x10,A5), then (0x11,3C).
//   2. Read 0x03, addr 0x000010, 2 dummy nibbles, 4 nibbles out -> sio_o A,5,3,C;
//      sio_oe rises only after the dummy nibbles.
//   3. Write at addr 0x01FFFF with ADDR_W=17, 2 bytes -> second byte lands at 0x00000.
//   4. Opcode 0x9F then 6 nibbles -> no mem_re/mem_we, sio_oe stays 0;
//      cmd_err=1 with QSPI_RESP_CMD_ERR_EN, 0 without.
//   5. cs_n rises after 3 write-data nibbles -> exactly 1 mem_we; FSM in IDLE, busy=0.
//   6. reset pulses during RDATA -> sio_oe=0 at once; the next full read returns correct data.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared QSPI target definitions: opcodes, wire-address width and responder FSM states.
package qspi_pkg;

  localparam int unsigned QSPI_WIRE_ADDR_W = 24;
  localparam int unsigned QSPI_NIB_W       = 4;

  localparam logic [7:0] QSPI_OP_READ  = 8'h03;
  localparam logic [7:0] QSPI_OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } qspi_state_e;

endpackage

// File: rtl/qspi_edge_sync.sv
// Two-flop synchronizers for cs_n/sck/sio plus edge pulses in the clk domain.
// Edge pulses are combinational from the synchronized flops (_c suffix).
module qspi_edge_sync
  import qspi_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_n,
  input  logic                  sck,
  input  logic [QSPI_NIB_W-1:0] sio_i,
  output logic [QSPI_NIB_W-1:0] sio_s,
  output logic                  cs_low_c,
  output logic                  cs_fall_c,
  output logic                  cs_rise_c,
  output logic                  sck_rise_c,
  output logic                  sck_fall_c
);

  logic                  cs_meta, cs_s, cs_d, cs_armed;
  logic                  sck_meta, sck_s, sck_d;
  logic [QSPI_NIB_W-1:0] sio_meta;

  // cs chain resets low and must see a real high before a fall counts,
  // so a cs_n held low across reset never starts a transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_meta  <= 1'b0;
      cs_s     <= 1'b0;
      cs_d     <= 1'b0;
      cs_armed <= 1'b0;
      sck_meta <= 1'b0;
      sck_s    <= 1'b0;
      sck_d    <= 1'b0;
      sio_meta <= '0;
      sio_s    <= '0;
    end else begin
      cs_meta  <= cs_n;
      cs_s     <= cs_meta;
      cs_d     <= cs_s;
      cs_armed <= cs_armed | cs_s;
      sck_meta <= sck;
      sck_s    <= sck_meta;
      sck_d    <= sck_s;
      sio_meta <= sio_i;
      sio_s    <= sio_meta;
    end
  end

  assign cs_low_c   = cs_armed & ~cs_s;
  assign cs_fall_c  = cs_d & ~cs_s;
  assign cs_rise_c  = cs_armed & ~cs_d & cs_s;
  assign sck_rise_c = sck_s & ~sck_d;
  assign sck_fall_c = ~sck_s & sck_d;

endmodule

// File: rtl/qspi_sram_responder.sv
// SQI-mode serial-SRAM target backed by a byte-wide synchronous memory port.
// Optional QSPI_RESP_CMD_ERR_EN: unknown opcodes set a sticky cmd_err flag.
module qspi_sram_responder
  import qspi_pkg::*;
#(
  parameter int unsigned ADDR_W        = 17,
  parameter int unsigned DUMMY_NIBBLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_n,
  input  logic                  sck,
  input  logic [QSPI_NIB_W-1:0] sio_i,
  output logic [QSPI_NIB_W-1:0] sio_o,
  output logic                  sio_oe,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam int unsigned CNT_W    = 5;
  localparam int unsigned ASR_W    = QSPI_WIRE_ADDR_W - QSPI_NIB_W;
  localparam int unsigned ADDR_NIB = QSPI_WIRE_ADDR_W / QSPI_NIB_W;

  logic [QSPI_NIB_W-1:0] sio_s;
  logic                  cs_low_c, cs_fall_c, cs_rise_c, sck_rise_c, sck_fall_c;
  logic                  rise_c, fall_c;

  qspi_state_e           state;
  logic [CNT_W-1:0]      nib_cnt;
  logic [7:0]            opcode;
  logic [ASR_W-1:0]      addr_sr;
  logic                  half;
  logic [QSPI_NIB_W-1:0] nib_hold;
  logic [7:0]            rd_buf;
  logic                  rd_pend;

  qspi_edge_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .cs_n       (cs_n),
    .sck        (sck),
    .sio_i      (sio_i),
    .sio_s      (sio_s),
    .cs_low_c   (cs_low_c),
    .cs_fall_c  (cs_fall_c),
    .cs_rise_c  (cs_rise_c),
    .sck_rise_c (sck_rise_c),
    .sck_fall_c (sck_fall_c)
  );

  assign rise_c = sck_rise_c & cs_low_c;
  assign fall_c = sck_fall_c & cs_low_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      nib_cnt   <= '0;
      opcode    <= '0;
      addr_sr   <= '0;
      half      <= 1'b0;
      nib_hold  <= '0;
      rd_buf    <= '0;
      rd_pend   <= 1'b0;
      sio_o     <= '0;
      sio_oe    <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
`ifdef QSPI_RESP_CMD_ERR_EN
      cmd_err   <= 1'b0;
`endif
    end else begin
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= cs_low_c;
      rd_pend <= mem_re;
      if (rd_pend) rd_buf <= mem_rdata;
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);

      if (cs_rise_c) begin
        state   <= ST_IDLE;
        sio_oe  <= 1'b0;
        half    <= 1'b0;
        nib_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall_c) begin
              state   <= ST_CMD;
              nib_cnt <= '0;
              half    <= 1'b0;
            end
          end

          ST_CMD: begin
            if (rise_c) begin
              opcode  <= {opcode[3:0], sio_s};
              nib_cnt <= nib_cnt + CNT_W'(1);
              if (nib_cnt == CNT_W'(1)) begin
                nib_cnt <= '0;
                if ({opcode[3:0], sio_s} == QSPI_OP_READ ||
                    {opcode[3:0], sio_s} == QSPI_OP_WRITE) begin
                  state <= ST_ADDR;
                end else begin
                  state <= ST_IGNORE;
`ifdef QSPI_RESP_CMD_ERR_EN
                  cmd_err <= 1'b1;
`endif
                end
              end
            end
          end

          ST_ADDR: begin
            if (rise_c) begin
              addr_sr <= {addr_sr[ASR_W-QSPI_NIB_W-1:0], sio_s};
              nib_cnt <= nib_cnt + CNT_W'(1);
              if (nib_cnt == CNT_W'(ADDR_NIB - 1)) begin
                nib_cnt  <= '0;
                mem_addr <= ADDR_W'({addr_sr, sio_s});
                if (opcode == QSPI_OP_READ) begin
                  mem_re <= 1'b1;
                  state  <= ST_DUMMY;
                end else begin
                  half  <= 1'b0;
                  state <= ST_WDATA;
                end
              end
            end
          end

          ST_DUMMY: begin
            if (rise_c) begin
              nib_cnt <= nib_cnt + CNT_W'(1);
              if (nib_cnt == CNT_W'(DUMMY_NIBBLES - 1)) begin
                nib_cnt <= '0;
                half    <= 1'b0;
                state   <= ST_RDATA;
              end
            end
          end

          // High nibble goes out and frees rd_buf, so the prefetch can overwrite it.
          ST_RDATA: begin
            if (fall_c) begin
              if (!half) begin
                sio_o    <= rd_buf[7:4];
                nib_hold <= rd_buf[3:0];
                sio_oe   <= 1'b1;
                mem_addr <= mem_addr + ADDR_W'(1);
                mem_re   <= 1'b1;
                half     <= 1'b1;
              end else begin
                sio_o <= nib_hold;
                half  <= 1'b0;
              end
            end
          end

          ST_WDATA: begin
            if (rise_c) begin
              if (!half) begin
                nib_hold <= sio_s;
                half     <= 1'b1;
              end else begin
                mem_wdata <= {nib_hold, sio_s};
                mem_we    <= 1'b1;
                half      <= 1'b0;
              end
            end
          end

          ST_IGNORE: ;

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifndef QSPI_RESP_CMD_ERR_EN
  assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Directed bench for qspi_sram_responder: QSPI initiator tasks plus a byte memory model.
module tb_qspi_sram_responder;
  import qspi_pkg::*;

  localparam int unsigned ADDR_W = 17;

  logic              clk = 1'b0;
  logic              reset;
  logic              cs_n;
  logic              sck;
  logic [3:0]        sio_i;
  logic [3:0]        sio_o;
  logic              sio_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [7:0]        mem_rdata = 8'h00;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              cmd_err;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_a [$];
  logic [7:0]        wr_d [$];
  int                n_re = 0;
  int                n_both = 0;
  int                n_oe = 0;
  int                checks = 0;
  int                passes = 0;
  logic              err_exp;

  qspi_sram_responder #(.ADDR_W(ADDR_W), .DUMMY_NIBBLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs_n      (cs_n),
    .sck       (sck),
    .sio_i     (sio_i),
    .sio_o     (sio_o),
    .sio_oe    (sio_oe),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory: read data valid the clk after mem_re.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      n_re      <= n_re + 1;
    end
    if (mem_re && mem_we) n_both <= n_both + 1;
    if (sio_oe) n_oe <= n_oe + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic nib_out(input logic [3:0] n);
    sio_i = n;
    #40 sck = 1'b1;
    #40 sck = 1'b0;
  endtask

  task automatic byte_out(input logic [7:0] b);
    nib_out(b[7:4]);
    nib_out(b[3:0]);
  endtask

  task automatic start_cmd(input logic [7:0] op, input logic [23:0] addr);
    cs_n = 1'b0;
    #80;
    byte_out(op);
    byte_out(addr[23:16]);
    byte_out(addr[15:8]);
    byte_out(addr[7:0]);
  endtask

  task automatic nib_in(input string tag, input logic [3:0] exp);
    #40;
    check(tag, 32'(sio_o), 32'(exp));
    sck = 1'b1;
    #40 sck = 1'b0;
  endtask

  task automatic end_cs();
    #40 cs_n = 1'b1;
    #120;
  endtask

  initial begin
    int base, re0, oe0;
`ifdef QSPI_RESP_CMD_ERR_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    reset = 1'b1; cs_n = 1'b1; sck = 1'b0; sio_i = 4'h0;
    #22;
    check("rst_sio_o",     32'(sio_o),     32'h0);
    check("rst_sio_oe",    32'(sio_oe),    32'h0);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_mem_re",    32'(mem_re),    32'h0);
    check("rst_mem_we",    32'(mem_we),    32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_cmd_err",   32'(cmd_err),   32'h0);
    reset = 1'b0;
    #50;

    // 1: write A5 3C at 0x10
    start_cmd(8'h02, 24'h000010);
    check("wr_busy", 32'(busy), 32'h1);
    byte_out(8'hA5);
    byte_out(8'h3C);
    end_cs();
    check("wr_count", 32'(wr_a.size()), 32'd2);
    check("wr0_addr", 32'(wr_a[0]), 32'h10);
    check("wr0_data", 32'(wr_d[0]), 32'hA5);
    check("wr1_addr", 32'(wr_a[1]), 32'h11);
    check("wr1_data", 32'(wr_d[1]), 32'h3C);
    check("wr_busy_end", 32'(busy), 32'h0);
    check("wr_oe_never", 32'(n_oe), 32'd0);

    // 2: read back from 0x10
    start_cmd(8'h03, 24'h000010);
    check("rd_oe_after_addr", 32'(sio_oe), 32'h0);
    nib_out(4'h0);
    check("rd_oe_dummy1", 32'(sio_oe), 32'h0);
    nib_out(4'h0);
    check("rd_oe_dummy2", 32'(sio_oe), 32'h0);
    nib_in("rd_n0", 4'hA);
    check("rd_oe_on", 32'(sio_oe), 32'h1);
    nib_in("rd_n1", 4'h5);
    nib_in("rd_n2", 4'h3);
    nib_in("rd_n3", 4'hC);
    end_cs();
    check("rd_oe_off", 32'(sio_oe), 32'h0);

    // 3: address wrap at 2^ADDR_W-1
    start_cmd(8'h02, 24'h01FFFF);
    byte_out(8'h11);
    byte_out(8'h22);
    end_cs();
    check("wrap_count", 32'(wr_a.size()), 32'd4);
    check("wrap0_addr", 32'(wr_a[2]), 32'h1FFFF);
    check("wrap0_data", 32'(wr_d[2]), 32'h11);
    check("wrap1_addr", 32'(wr_a[3]), 32'h00000);
    check("wrap1_data", 32'(wr_d[3]), 32'h22);

    // 4: unknown opcode
    base = wr_a.size(); re0 = n_re; oe0 = n_oe;
    cs_n = 1'b0;
    #80;
    byte_out(8'h9F);
    byte_out(8'h12);
    byte_out(8'h34);
    byte_out(8'h56);
    end_cs();
    check("bad_no_we", 32'(wr_a.size()), 32'(base));
    check("bad_no_re", 32'(n_re), 32'(re0));
    check("bad_no_oe", 32'(n_oe), 32'(oe0));
    check("bad_cmd_err", 32'(cmd_err), 32'(err_exp));

    // 5: cs_n rises after three write nibbles
    base = wr_a.size();
    start_cmd(8'h02, 24'h000020);
    nib_out(4'h7);
    nib_out(4'hE);
    nib_out(4'h4);
    end_cs();
    check("part_count", 32'(wr_a.size()), 32'(base + 1));
    check("part_addr", 32'(wr_a[base]), 32'h20);
    check("part_data", 32'(wr_d[base]), 32'h7E);
    check("part_busy", 32'(busy), 32'h0);
    check("part_state", 32'(dut.state), 32'(ST_IDLE));
    check("part_cmd_err_sticky", 32'(cmd_err), 32'(err_exp));

    // 6: reset during read data, then a clean read
    start_cmd(8'h03, 24'h000010);
    nib_out(4'h0);
    nib_out(4'h0);
    nib_in("rst_rd_n0", 4'hA);
    #20 reset = 1'b1;
    #1;
    check("rst_mid_oe", 32'(sio_oe), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_addr", 32'(mem_addr), 32'h0);
    check("rst_mid_cmd_err", 32'(cmd_err), 32'h0);
    #20 reset = 1'b0;
    #40 cs_n = 1'b1;
    #120;
    start_cmd(8'h03, 24'h000010);
    nib_out(4'h0);
    nib_out(4'h0);
    nib_in("rd2_n0", 4'hA);
    nib_in("rd2_n1", 4'h5);
    nib_in("rd2_n2", 4'h3);
    nib_in("rd2_n3", 4'hC);
    end_cs();
    check("no_re_we_overlap", 32'(n_both), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
